// File: rtl/systolic_array_obi_streamer.sv
// systolic_array_obi_streamer
// Bus-master DMA that streams COUNT words from a source buffer into the
// systolic array command window, optionally copying the array output back to
// a destination buffer after every QUEUE/STREAM write.
//
// Ports
//   clk_i       clock
//   rst_n       synchronous reset, active low
//   start_i     1-cycle pulse: latch config and begin a job (ignored while busy)
//   cmd_i       array command, placed on addr[19:18] of array writes
//   src_addr_i  word-aligned source buffer base
//   dst_addr_i  word-aligned write-back buffer base
//   count_i     number of elements
//   writeback_i read back the array output after each QUEUE/STREAM write
//   busy_o      job in progress
//   done_o      1-cycle pulse at job completion
//   obi_req_o   OBI master request
//   obi_resp_i  OBI response
//
// state        | meaning
// IDLE         | waiting for start_i
// RD_REQ       | source read request (also the count==0 exit point)
// RD_WAIT      | waiting for source read data
// WR_REQ       | array command write request
// WR_WAIT      | waiting for array write response
// OUT_RD_REQ   | array output read request
// OUT_RD_WAIT  | waiting for array output data
// OUT_WR_REQ   | destination write request
// OUT_WR_WAIT  | waiting for destination write response
// DONE         | one-cycle completion, done_o high

package sa_obi_streamer_pkg;
  typedef enum logic [1:0] {
    CMD_WRITE_WEIGHTS = 2'd0,
    CMD_QUEUE         = 2'd1,
    CMD_STREAM        = 2'd2,
    CMD_CLEAR         = 2'd3
  } command_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module systolic_array_obi_streamer
  import sa_obi_streamer_pkg::*;
#(
  parameter logic [31:0] SA_BASE_ADDR = 32'h0000_0000,
  parameter int          SA_SIZE      = 4,
  parameter int          LOG_SA_SIZE  = $clog2(SA_SIZE),
  parameter int          COUNT_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  command_t               cmd_i,
  input  logic [31:0]            src_addr_i,
  input  logic [31:0]            dst_addr_i,
  input  logic [COUNT_WIDTH-1:0] count_i,
  input  logic                   writeback_i,
  output logic                   busy_o,
  output logic                   done_o,
  output obi_req_t               obi_req_o,
  input  obi_resp_t              obi_resp_i
);

  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT,
    OUT_RD_REQ, OUT_RD_WAIT, OUT_WR_REQ, OUT_WR_WAIT, DONE
  } state_t;

  state_t                 state_q;
  command_t               cmd_q;
  logic [31:0]            src_q;
  logic [31:0]            dst_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] idx_q;
  logic                   wb_q;

  logic [COUNT_WIDTH:0]   idx_inc;
  logic                   last_elem;
  logic [31:0]            sa_addr;
  logic [31:0]            dst_addr;
  logic [31:0]            src_addr_next;

  // Extra counter bit keeps idx+1 < count correct at count = 2^COUNT_WIDTH-1.
  assign idx_inc       = {1'b0, idx_q} + 1'b1;
  assign last_elem     = idx_inc >= {1'b0, count_q};
  assign sa_addr       = SA_BASE_ADDR | (32'(cmd_q) << 18) | (32'(idx_q[LOG_SA_SIZE-1:0]) << 2);
  assign dst_addr      = dst_q + (32'(idx_q) << 2);
  assign src_addr_next = src_q + (32'(idx_inc[COUNT_WIDTH-1:0]) << 2);

  // Request outputs are registered and loaded on entry to each *_REQ state,
  // so they stay stable for as long as gnt is withheld.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      obi_req_o.req   <= 1'b0;
      obi_req_o.we    <= 1'b0;
      obi_req_o.be    <= 4'hF;
      obi_req_o.addr  <= 32'h0;
      obi_req_o.wdata <= 32'h0;
      cmd_q           <= CMD_WRITE_WEIGHTS;
      src_q           <= 32'h0;
      dst_q           <= 32'h0;
      count_q         <= '0;
      idx_q           <= '0;
      wb_q            <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            cmd_q   <= cmd_i;
            src_q   <= src_addr_i;
            dst_q   <= dst_addr_i;
            count_q <= count_i;
            wb_q    <= writeback_i && (cmd_i == CMD_QUEUE || cmd_i == CMD_STREAM);
            idx_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= RD_REQ;
            // count==0 passes through RD_REQ without ever raising req.
            if (count_i != '0) begin
              obi_req_o.req  <= 1'b1;
              obi_req_o.we   <= 1'b0;
              obi_req_o.addr <= src_addr_i;
            end
          end
        end
        RD_REQ: begin
          if (count_q == '0) begin
            done_o  <= 1'b1;
            state_q <= DONE;
          end else if (obi_resp_i.gnt) begin
            obi_req_o.req <= 1'b0;
            state_q       <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (obi_resp_i.rvalid) begin
            obi_req_o.req   <= 1'b1;
            obi_req_o.we    <= 1'b1;
            obi_req_o.addr  <= sa_addr;
            obi_req_o.wdata <= obi_resp_i.rdata;
            state_q         <= WR_REQ;
          end
        end
        WR_REQ, OUT_RD_REQ, OUT_WR_REQ: begin
          if (obi_resp_i.gnt) begin
            obi_req_o.req <= 1'b0;
            state_q <= (state_q == WR_REQ)     ? WR_WAIT :
                       (state_q == OUT_RD_REQ) ? OUT_RD_WAIT : OUT_WR_WAIT;
          end
        end
        OUT_RD_WAIT: begin
          if (obi_resp_i.rvalid) begin
            obi_req_o.req   <= 1'b1;
            obi_req_o.we    <= 1'b1;
            obi_req_o.addr  <= dst_addr;
            obi_req_o.wdata <= obi_resp_i.rdata;
            state_q         <= OUT_WR_REQ;
          end
        end
        WR_WAIT, OUT_WR_WAIT: begin
          if (obi_resp_i.rvalid) begin
            if (state_q == WR_WAIT && wb_q) begin
              obi_req_o.req  <= 1'b1;
              obi_req_o.we   <= 1'b0;
              obi_req_o.addr <= SA_BASE_ADDR;
              state_q        <= OUT_RD_REQ;
            end else if (last_elem) begin
              done_o  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q          <= idx_inc[COUNT_WIDTH-1:0];
              obi_req_o.req  <= 1'b1;
              obi_req_o.we   <= 1'b0;
              obi_req_o.addr <= src_addr_next;
              state_q        <= RD_REQ;
            end
          end
        end
        DONE: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_obi_streamer.sv
module tb_systolic_array_obi_streamer;
  import sa_obi_streamer_pkg::*;

  localparam logic [31:0] SA_BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  command_t    cmd;
  logic [31:0] src, dst;
  logic [15:0] count;
  logic        wb;
  logic        busy_o, done_o;
  obi_req_t    obi_req;
  obi_resp_t   obi_resp;

  systolic_array_obi_streamer #(
    .SA_BASE_ADDR(SA_BASE), .SA_SIZE(4), .LOG_SA_SIZE(2), .COUNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_n(rst_n), .start_i(start), .cmd_i(cmd),
    .src_addr_i(src), .dst_addr_i(dst), .count_i(count), .writeback_i(wb),
    .busy_o(busy_o), .done_o(done_o), .obi_req_o(obi_req), .obi_resp_i(obi_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_rv = -1;
  int          stall_mode = 0;
  int          wait_cnt = 0;
  logic [31:0] mem [logic [31:0]];
  txn_t        obs_q[$];
  logic        gnt, rvalid_r;
  logic [31:0] rdata_r, sa_out;
  bit          have_prev;
  obi_req_t    prev_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Array output register behaviour: result derived from the last command word.
  function automatic logic [31:0] sa_fn(input logic [31:0] x);
    return (x * 32'd3) ^ 32'h0F0F_0000;
  endfunction

  assign gnt      = obi_req.req && (wait_cnt == 0);
  assign obi_resp = {gnt, rvalid_r, rdata_r};

  always @(posedge clk) cyc <= cyc + 1;

  // Memory + array responder: answers one cycle after gnt, optional backpressure.
  always @(posedge clk) begin
    if (!rst_n) begin
      rvalid_r  <= 1'b0;
      wait_cnt  <= 0;
      have_prev <= 1'b0;
    end else begin
      rvalid_r <= 1'b0;
      if (obi_req.req && gnt) begin
        obs_q.push_back('{obi_req.we, obi_req.addr, obi_req.wdata});
        if (obi_req.we) begin
          if (obi_req.addr[31:20] == SA_BASE[31:20]) sa_out = sa_fn(obi_req.wdata);
          else mem[obi_req.addr] = obi_req.wdata;
        end else begin
          rdata_r <= (obi_req.addr[31:20] == SA_BASE[31:20]) ? sa_out : mem_rd(obi_req.addr);
        end
        rvalid_r  <= 1'b1;
        have_prev <= 1'b0;
        wait_cnt  <= (stall_mode == 0) ? 0 : (stall_mode == 1) ? 5 : int'($urandom_range(0, 5));
      end else if (obi_req.req) begin
        if (have_prev) begin
          check("stall_addr", obi_req.addr, prev_req.addr);
          check("stall_we", 32'(obi_req.we), 32'(prev_req.we));
          check("stall_wdata", obi_req.wdata, prev_req.wdata);
        end
        prev_req  <= obi_req;
        have_prev <= 1'b1;
        wait_cnt  <= wait_cnt - 1;
      end
    end
  end

  always @(negedge clk) if (obi_resp.rvalid) last_rv = cyc;

  task automatic run_job(input command_t c, input logic [31:0] s, input logic [31:0] d,
                         input int n, input bit wbi, input int smode, input bit poke);
    txn_t exp_q[$];
    logic [31:0] v;
    int done_n = 0;
    int done_c = -1;
    int start_c;
    bit wbe;
    wbe = wbi && (c == CMD_QUEUE || c == CMD_STREAM);
    for (int i = 0; i < n; i++) begin
      v = mem_rd(s + 32'(4 * i));
      exp_q.push_back('{1'b0, s + 32'(4 * i), 32'h0});
      exp_q.push_back('{1'b1, SA_BASE | (32'(c) << 18) | (32'(i % 4) << 2), v});
      if (wbe) begin
        exp_q.push_back('{1'b0, SA_BASE, 32'h0});
        exp_q.push_back('{1'b1, d + 32'(4 * i), sa_fn(v)});
      end
    end
    stall_mode = smode;
    obs_q.delete();
    last_rv = -1;
    @(negedge clk);
    cmd = c; src = s; dst = d; count = 16'(n); wb = wbi; start = 1'b1;
    start_c = cyc;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start = (poke && k == 2);
      if (poke && k == 2) begin
        cmd = CMD_CLEAR; src = 32'hDEAD_0000; dst = 32'hBEEF_0000; count = 16'd9; wb = 1'b0;
      end
      if (k == 0) check("busy_after_start", 32'(busy_o), 32'd1);
      if (done_o) begin
        done_n++;
        if (done_c < 0) done_c = cyc;
      end
      if (done_c >= 0 && cyc == done_c + 1) check("busy_after_done", 32'(busy_o), 32'd0);
      if (done_c >= 0 && cyc >= done_c + 3) break;
    end
    start = 1'b0;
    check("done_pulses", 32'(done_n), 32'd1);
    check("done_time", 32'(done_c), (n == 0) ? 32'(start_c + 2) : 32'(last_rv + 1));
    check("txn_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check("txn_we", 32'(obs_q[i].we), 32'(exp_q[i].we));
      check("txn_addr", obs_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) check("txn_wdata", obs_q[i].wdata, exp_q[i].wdata);
    end
    if (wbe)
      for (int i = 0; i < n; i++)
        check("dst_mem", mem_rd(d + 32'(4 * i)), sa_fn(mem_rd(s + 32'(4 * i))));
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) mem[base + 32'(4 * i)] = $urandom;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b1; cmd = CMD_QUEUE; src = 32'h0; dst = 32'h0;
    count = 16'd3; wb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_req", 32'(obi_req.req), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
    end
    check("rst_be", 32'(obi_req.be), 32'hF);
    check("rst_addr", obi_req.addr, 32'h0);
    start = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mem[32'h1000] = 32'd1; mem[32'h1004] = 32'hFFFF_FFFF;
    mem[32'h1008] = 32'd127; mem[32'h100C] = 32'hFFFF_FF80;
    run_job(CMD_WRITE_WEIGHTS, 32'h1000, 32'h7000, 4, 1'b1, 0, 1'b0);

    fill(32'h3000, 6);
    run_job(CMD_STREAM, 32'h3000, 32'h2000, 6, 1'b1, 0, 1'b1);
    run_job(CMD_STREAM, 32'h3000, 32'h5000, 6, 1'b1, 1, 1'b0);
    for (int i = 0; i < 6; i++)
      check("stall_vs_nostall", mem_rd(32'h5000 + 32'(4 * i)), mem_rd(32'h2000 + 32'(4 * i)));

    fill(32'h8000, 5);
    run_job(CMD_QUEUE, 32'h8000, 32'h9000, 5, 1'b1, 2, 1'b0);
    run_job(CMD_QUEUE, 32'h8000, 32'hA000, 0, 1'b1, 0, 1'b0);
    fill(32'hFFFF_FFF8, 3);
    run_job(CMD_CLEAR, 32'hFFFF_FFF8, 32'hB000, 3, 1'b1, 0, 1'b0);

    // Reset while element 2's array write is outstanding.
    fill(32'h6000, 4);
    stall_mode = 0;
    obs_q.delete();
    @(negedge clk);
    cmd = CMD_WRITE_WEIGHTS; src = 32'h6000; count = 16'd4; wb = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      if (obs_q.size() == 6) begin seen = 1; break; end
      @(negedge clk);
    end
    check("reach_wr_wait_elem2", 32'(seen), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_req", 32'(obi_req.req), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_o || obi_req.req) seen++;
    end
    check("midrst_quiet", 32'(seen), 32'd0);
    run_job(CMD_WRITE_WEIGHTS, 32'h6000, 32'h0, 4, 1'b0, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
